// File: rtl/ahb_arbiter.sv
// AHB2 (non-split) bus arbiter: round-robin grant hand-over at burst boundaries, held through locked sequences.
// Define ARB_FIXED_PRIORITY_EN to replace the rotation with fixed priority (master 0 highest).
module ahb_arbiter #(
   parameter int NUM_MASTER     = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic [NUM_MASTER-1:0] HBUSREQ,
   input  logic [NUM_MASTER-1:0] HLOCK,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HBURST,
   input  logic                  HREADY,
   output logic [NUM_MASTER-1:0] HGRANT,
   output logic [3:0]            HMASTER,
   output logic                  HMASTLOCK
);

   localparam int IW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
   localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_BUSY   = 2'd1;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   logic [3:0]    bl;
   logic [3:0]    bl_next;
   logic [IW-1:0] owner;
   logic [IW-1:0] winner;
   logic          lock_hold;
   logic          arb_ok;

   // Remaining-beat count after this edge; fixed bursts load their length minus one.
   always_comb begin
      bl_next = bl;
      case (HTRANS)
         TR_NONSEQ: begin
            case (HBURST)
               3'd2, 3'd3: bl_next = 4'd3;
               3'd4, 3'd5: bl_next = 4'd7;
               3'd6, 3'd7: bl_next = 4'd15;
               default:    bl_next = 4'd0;
            endcase
         end
         TR_SEQ:  bl_next = (bl == 4'd0) ? 4'd0 : bl - 4'd1;
         TR_IDLE: bl_next = 4'd0;
         TR_BUSY: bl_next = bl;
         default: bl_next = bl;
      endcase
   end

   assign arb_ok = HREADY && (bl_next <= 4'd1) && !HLOCK[owner] && !lock_hold;

`ifdef ARB_FIXED_PRIORITY_EN
   // Scanning downward leaves the lowest-index requester as the winner.
   always_comb begin
      winner = DEF_IDX;
      for (int i = NUM_MASTER - 1; i >= 0; i--) begin
         if (HBUSREQ[IW'(i)]) winner = IW'(i);
      end
   end
`else
   logic [IW-1:0] rr_ptr;
   int            cand;

   // Scan from the farthest candidate back toward rr_ptr+1 so the nearest requester wins; the owner itself comes last.
   always_comb begin
      winner = DEF_IDX;
      cand   = 0;
      for (int i = NUM_MASTER; i >= 1; i--) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_MASTER) cand = cand - NUM_MASTER;
         if (HBUSREQ[IW'(cand)]) winner = IW'(cand);
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rr_ptr <= DEF_IDX;
      end else if (arb_ok) begin
         rr_ptr <= winner;
      end
   end
`endif

   // Everything advances only on HREADY edges; HMASTER/HMASTLOCK follow the grant by one accepted transfer.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         HGRANT    <= NUM_MASTER'(1) << DEF_IDX;
         owner     <= DEF_IDX;
         HMASTER   <= 4'(DEF_IDX);
         HMASTLOCK <= 1'b0;
         bl        <= 4'd0;
         lock_hold <= 1'b0;
      end else if (HREADY) begin
         bl        <= bl_next;
         lock_hold <= HLOCK[owner];
         HMASTER   <= 4'(owner);
         HMASTLOCK <= HLOCK[owner];
         if (arb_ok) begin
            owner  <= winner;
            HGRANT <= NUM_MASTER'(1) << winner;
         end
      end
   end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- AMBA AHB (AHB2, non-split) bus arbiter for up to 16 masters sharing one AHB bus.
- Replaces the HGRANT=HBUSREQ tie-off in multi-master benches, e.g. several bfm_ahb instances or ahb2ahb mHBUSREQ/mHGRANT ports in front of ahb_lite_s3.
- Monitors shared HTRANS/HBURST/HREADY so grant hand-over happens only at legal burst boundaries and is held during locked sequences.
- Drives HGRANTx, HMASTER and HMASTLOCK.

Parameters:
NUM_MASTER, 4, number of masters (2..16).
DEFAULT_MASTER, 0, master parked on the bus when nobody requests.

Ports:
HCLK  input  1  bus clock
HRESET  input  1  synchronous reset, active-high
HBUSREQ  input  NUM_MASTER  per-master bus request
HLOCK  input  NUM_MASTER  per-master locked-transfer request
HTRANS  input  2  shared-bus transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
HBURST  input  3  shared-bus burst type
HREADY  input  1  shared-bus ready (slave mux output)
HGRANT  output  NUM_MASTER  one-hot grant
HMASTER  output  4  index of master owning the address phase
HMASTLOCK  output  1  current address phase is locked

Behaviour:
- Reset (HRESET=1 at posedge HCLK):
  - HGRANT = 1<<DEFAULT_MASTER; HMASTER = DEFAULT_MASTER; HMASTLOCK = 0.
  - Beat counter = 0; round-robin pointer = DEFAULT_MASTER.
  - A reset mid-burst aborts everything to these values on the same edge.
- All outputs are registered. HGRANT is always exactly one-hot.
- Beat counter (bl), updated only on edges with HREADY=1:
  - NONSEQ with HBURST in {WRAP4, INCR4}: bl = 3. {WRAP8, INCR8}: bl = 7. {WRAP16, INCR16}: bl = 15.
  - NONSEQ with SINGLE or INCR: bl = 0.
  - SEQ: bl = bl-1, saturating at 0.
  - IDLE: bl = 0. BUSY: bl unchanged.
- Arbitration enable (arb_ok) is evaluated on every HREADY=1 edge and is true when all of:
  - next bl <= 1;
  - HLOCK[owner] = 0, where owner = master currently holding HGRANT;
  - locked-hold flag is clear.
  - This places the grant change during the last address beat, so the new master's first address phase directly follows the old burst.
  - Early burst termination (NONSEQ/IDLE mid-burst) resets bl, so arbitration is allowed at once.
- When arb_ok:
  - Winner is the first requesting master searching from owner+1 upward, modulo NUM_MASTER. The owner itself is considered last.
  - If no HBUSREQ is set, the winner is DEFAULT_MASTER.
  - HGRANT is loaded with the winner; the round-robin pointer is set to the winner.
- When arb_ok is false, or HREADY=0: HGRANT holds.
- HMASTER / HMASTLOCK are loaded only on HREADY=1 edges: HMASTER = index of HGRANT, HMASTLOCK = HLOCK[index of HGRANT]. They therefore track address-phase ownership one cycle after the grant.
- Locked-hold flag:
  - Set on an HREADY=1 edge with HLOCK[owner]=1.
  - Cleared on the first HREADY=1 edge after HLOCK[owner] has dropped.
  - Effect: the grant is held for one extra transfer after lock release (AHB rule).
- HRESP is not observed. SPLIT and RETRY are unsupported; masters retry while still granted.
- Simultaneous cases:
  - Request and de-assert in the same cycle by different masters: the rotation decides.
  - The owner dropping HBUSREQ on a non-arb_ok edge does not remove its grant.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: the winner is the lowest-index requesting master (master 0 highest priority). The round-robin pointer is unused. All burst and lock rules are unchanged.
- Undefined: round-robin as above.

Test Plan:
1. Reset, NUM_MASTER=4, no requests -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0. Hold reset mid-burst -> same values on the next edge.
2. Masters 1 and 2 request continuously; each does INCR4 (NONSEQ + 3 SEQ, HREADY=1) -> grant alternates 1, 2, 1. HGRANT changes on the edge accepting the 3rd beat; HMASTER changes one edge later; no beat lost.
3. Master 3 owns bus in an INCR8 burst with HREADY=0 for 2 cycles on beat 5; master 0 requests -> HGRANT stays 4'b1000 until the 7th beat is accepted, then becomes 4'b0001.
4. Master 1 asserts HLOCK for 3 SINGLE transfers while master 2 requests -> HMASTLOCK=1 for those 3 address phases. Grant stays with 1 until one transfer after HLOCK drops, then goes to 2.
5. Master 2 does an undefined-length INCR while master 0 requests -> grant moves to 0 at the next HREADY=1 edge.
6. With ARB_FIXED_PRIORITY_EN, masters 1, 2 and 3 request continuously with SINGLE transfers -> master 1 keeps the grant every cycle; 2 and 3 are never granted until 1 drops HBUSREQ.
